// File: rtl/rx_deserializer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rx_deserializer_if                                                      |
// | Parallel output port of the serial receiver: word, status and handshake |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface rx_deserializer_if #(
  parameter int BIT_LEN = 7
);
  logic [BIT_LEN-1:0] data_out;
  logic               data_valid;
  logic               data_ready;
  logic               parity_err;
  logic               overrun;
  logic               frame_err;

  modport master (
    output data_out, data_valid, parity_err, overrun, frame_err,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_err, overrun, frame_err,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/rx_deserializer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rx_deserializer                                                         |
// | Serial frame receiver with parity check and one-entry holding register. |
// | Optional stop-bit checking enabled by defining RX_STOP_CHECK_EN.        |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module rx_deserializer #(
  parameter int BIT_LEN = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              channel_in,
  rx_deserializer_if.master rx
);
  localparam int CNT_W = $clog2(BIT_LEN + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PARITY = 3'd1,
    DATA   = 3'd2,
    STOP1  = 3'd3,
    STOP2  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_LEN-1:0] shift_q, shift_d;
  logic [BIT_LEN-1:0] data_q, data_d;
  logic               parity_q, parity_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               overrun_q, overrun_d;
  logic               pop;
  logic               complete;
`ifdef RX_STOP_CHECK_EN
  logic               frame_err_q, frame_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    parity_d  = parity_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    overrun_d = 1'b0;
    complete  = 1'b0;
    pop       = valid_q && rx.data_ready;
`ifdef RX_STOP_CHECK_EN
    frame_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (channel_in) state_d = PARITY;
      end
      PARITY: begin
        parity_d = channel_in;
        cnt_d    = '0;
        state_d  = DATA;
      end
      DATA: begin
        shift_d[cnt_q] = channel_in;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIT_LEN - 1)) state_d = STOP1;
      end
      STOP1: begin
`ifdef RX_STOP_CHECK_EN
        if (!channel_in) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          state_d = STOP2;
        end
`else
        state_d = STOP2;
`endif
      end
      STOP2: begin
        state_d = IDLE;
`ifdef RX_STOP_CHECK_EN
        if (!channel_in) frame_err_d = 1'b1;
        else             complete    = 1'b1;
`else
        complete = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    // A pop on the completion edge frees the slot for the new word.
    if (complete && (!valid_q || pop)) begin
      data_d  = shift_q;
      perr_d  = (parity_q != ^shift_q);
      valid_d = 1'b1;
    end else begin
      if (complete) overrun_d = 1'b1;
      if (pop)      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef RX_STOP_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_err_q <= 1'b0;
    else       frame_err_q <= frame_err_d;
  end
  assign rx.frame_err = frame_err_q;
`else
  assign rx.frame_err = 1'b0;
`endif

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.overrun    = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_rx_deserializer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_rx_deserializer                                                      |
// | Self-checking bench for rx_deserializer with an expected-word queue.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_rx_deserializer;
  localparam int BIT_LEN = 7;

  logic clk;
  logic rstn;
  logic channel_in;

  rx_deserializer_if #(.BIT_LEN(BIT_LEN)) rx_if ();

  rx_deserializer #(.BIT_LEN(BIT_LEN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .channel_in (channel_in),
    .rx         (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [BIT_LEN-1:0] d;
    logic               p;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the first n line bits of a frame; returns 1 time unit after the last edge.
  task automatic send_frame(input logic [BIT_LEN-1:0] d, input logic par,
                            input logic stop2, input int rdy_last, input int n);
    logic [BIT_LEN+3:0] bits;
    bits = {stop2, 1'b1, d, par, 1'b1};
    for (int i = 0; i < n; i++) begin
      channel_in = bits[i];
      if (i == BIT_LEN + 3 && rdy_last >= 0) rx_if.data_ready = rdy_last[0];
      tick();
    end
    channel_in = 1'b0;
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got data=%h perr=%b", name,
               rx_if.data_out, rx_if.parity_err);
    end else begin
      e = sb.pop_front();
      if ({rx_if.data_valid, rx_if.data_out, rx_if.parity_err} !== {1'b1, e.d, e.p}) begin
        n_fail++;
        $display("FAIL %s: got valid=%b data=%h perr=%b, want valid=1 data=%h perr=%b",
                 name, rx_if.data_valid, rx_if.data_out, rx_if.parity_err, e.d, e.p);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if ({rx_if.data_out, rx_if.data_valid, rx_if.parity_err, rx_if.overrun,
         rx_if.frame_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b ov=%b fe=%b, want all 0",
               rx_if.data_out, rx_if.data_valid, rx_if.parity_err, rx_if.overrun,
               rx_if.frame_err);
    end
    rstn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    rx_if.data_ready = 1'b1;
    sb.push_back('{d: 7'h55, p: 1'b0});
    send_frame(7'h55, 1'b0, 1'b1, -1, BIT_LEN + 4);
    check_pop("basic_55");
    tick();
    n_cmp++;
    if (rx_if.data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_drop: got %b want 0", rx_if.data_valid);
    end
  endtask

  task automatic test_parity_err();
    rx_if.data_ready = 1'b1;
    sb.push_back('{d: 7'h03, p: 1'b1});
    send_frame(7'h03, 1'b1, 1'b1, -1, BIT_LEN + 4);
    check_pop("parity_err_03");
    repeat (2) tick();
  endtask

  task automatic test_overrun();
    rx_if.data_ready = 1'b0;
    sb.push_back('{d: 7'h11, p: 1'b0});
    send_frame(7'h11, ^7'h11, 1'b1, -1, BIT_LEN + 4);
    check_pop("overrun_hold_11");
    n_cmp++;
    if (rx_if.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_first: got %b want 0", rx_if.overrun);
    end
    tick();
    send_frame(7'h22, ^7'h22, 1'b1, -1, BIT_LEN + 4);
    n_cmp++;
    if ({rx_if.overrun, rx_if.data_valid, rx_if.data_out} !== {1'b1, 1'b1, 7'h11}) begin
      n_fail++;
      $display("FAIL overrun_pulse: got ov=%b v=%b data=%h want ov=1 v=1 data=11",
               rx_if.overrun, rx_if.data_valid, rx_if.data_out);
    end
    tick();
    n_cmp++;
    if ({rx_if.overrun, rx_if.data_out} !== {1'b0, 7'h11}) begin
      n_fail++;
      $display("FAIL overrun_one_cycle: got ov=%b data=%h want ov=0 data=11",
               rx_if.overrun, rx_if.data_out);
    end
    rx_if.data_ready = 1'b1;
    tick();
    n_cmp++;
    if ({rx_if.data_valid, rx_if.data_out} !== {1'b0, 7'h11}) begin
      n_fail++;
      $display("FAIL overrun_pop: got v=%b data=%h want v=0 data=11",
               rx_if.data_valid, rx_if.data_out);
    end
  endtask

  task automatic test_pop_same_edge();
    rx_if.data_ready = 1'b0;
    sb.push_back('{d: 7'h11, p: 1'b0});
    send_frame(7'h11, ^7'h11, 1'b1, -1, BIT_LEN + 4);
    check_pop("same_edge_hold_11");
    tick();
    sb.push_back('{d: 7'h7F, p: 1'b0});
    send_frame(7'h7F, ^7'h7F, 1'b1, 1, BIT_LEN + 4);
    check_pop("same_edge_7f");
    n_cmp++;
    if (rx_if.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL same_edge_overrun: got %b want 0", rx_if.overrun);
    end
    tick();
  endtask

  task automatic test_stop_err();
    rx_if.data_ready = 1'b1;
    repeat (2) tick();
`ifdef RX_STOP_CHECK_EN
    send_frame(7'h2A, ^7'h2A, 1'b0, -1, BIT_LEN + 4);
    n_cmp++;
    if ({rx_if.frame_err, rx_if.data_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL stop_err_pulse: got fe=%b v=%b want fe=1 v=0",
               rx_if.frame_err, rx_if.data_valid);
    end
    tick();
    n_cmp++;
    if (rx_if.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_err_one_cycle: got %b want 0", rx_if.frame_err);
    end
`else
    sb.push_back('{d: 7'h2A, p: 1'b0});
    send_frame(7'h2A, ^7'h2A, 1'b0, -1, BIT_LEN + 4);
    check_pop("stop_ignored_2a");
    n_cmp++;
    if (rx_if.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_ignored_fe: got %b want 0", rx_if.frame_err);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    rx_if.data_ready = 1'b0;
    sb.push_back('{d: 7'h03, p: 1'b1});
    send_frame(7'h03, 1'b1, 1'b1, -1, BIT_LEN + 4);
    check_pop("mid_reset_hold");
    tick();
    send_frame(7'h6B, ^7'h6B, 1'b1, -1, 5);
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({rx_if.data_out, rx_if.data_valid, rx_if.parity_err, rx_if.overrun} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got data=%h v=%b pe=%b ov=%b want all 0",
               rx_if.data_out, rx_if.data_valid, rx_if.parity_err, rx_if.overrun);
    end
    tick();
    rstn = 1'b1;
    repeat (2) tick();
    rx_if.data_ready = 1'b1;
    sb.push_back('{d: 7'h01, p: 1'b0});
    send_frame(7'h01, ^7'h01, 1'b1, -1, BIT_LEN + 4);
    check_pop("after_reset_01");
    tick();
  endtask

  task automatic test_back_to_back();
    logic [BIT_LEN-1:0] d;
    rx_if.data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = BIT_LEN'($urandom_range(0, (1 << BIT_LEN) - 1));
      sb.push_back('{d: d, p: 1'b0});
      send_frame(d, ^d, 1'b1, -1, BIT_LEN + 4);
      check_pop("back_to_back");
      tick();
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    channel_in       = 1'b0;
    rx_if.data_ready = 1'b0;
    rstn             = 1'b0;
    test_reset();
    test_basic();
    test_parity_err();
    test_overrun();
    test_pop_same_edge();
    test_stop_err();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
